hit_resolver: RTL and testbench

Frame-rate combat referee that sits directly downstream of the two `player` instances. Each frame it compares each attacker's basic hit box against the opponent's main hurtbox and registers at most one hit per attack. On a hit it decrements the defender's health and applies hit-stun. It also runs the round state machine (fight / KO / draw) whose outputs feed the HEX displays, LEDs and the VGA overlay.

---
 rtl/hit_resolver.sv | 200 ++++++++++++++++++++
 tb/tb_hit_resolver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_resolver.sv
// hit_resolver: frame-rate combat referee between two players.
// Registers at most one hit per attack swing, tracks health and hit-stun,
// and runs the round state machine (fight / P1 wins / P2 wins / draw).
//
// Ports:
//   clk, rst               system clock, asynchronous active-high reset
//   tick                   one-cycle frame strobe; game logic advances on it
//   restart                level; starts a new round on any clk
//   p1_state, p2_state     player FSM state codes (4 bits)
//   p*_hit_{x1,x2,y1,y2}   basic hit boxes, inclusive corners (10 bits)
//   p*_hurt_{x1,x2,y1,y2}  main hurtboxes, inclusive corners (10 bits)
//   p1_health, p2_health   current health (4 bits)
//   p1_stun, p2_stun       high while that player's stun counter is non-zero
//   p1_hit, p2_hit         one-clk pulse when that player takes a hit
//   round_state            0=FIGHT 1=P1_WINS 2=P2_WINS 3=DRAW
module hit_resolver #(
    parameter int          MAX_HEALTH   = 3,
    parameter int          STUN_FRAMES  = 30,
    parameter logic [3:0]  ACTIVE_STATE = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       restart,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_hit_x1,
    input  logic [9:0] p1_hit_x2,
    input  logic [9:0] p1_hit_y1,
    input  logic [9:0] p1_hit_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_hit_x1,
    input  logic [9:0] p2_hit_x2,
    input  logic [9:0] p2_hit_y1,
    input  logic [9:0] p2_hit_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
    output logic [3:0] p1_health,
    output logic [3:0] p2_health,
    output logic       p1_stun,
    output logic       p2_stun,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic [1:0] round_state
);

    typedef enum logic [1:0] {
        FIGHT   = 2'd0,
        P1_WINS = 2'd1,
        P2_WINS = 2'd2,
        DRAW    = 2'd3
    } round_t;

    localparam logic [3:0] HEALTH_INIT = 4'(MAX_HEALTH);
    localparam logic [7:0] STUN_INIT   = 8'(STUN_FRAMES);

    round_t     r_round;
    logic [3:0] r_p1_health;
    logic [3:0] r_p2_health;
    logic [7:0] r_p1_cnt;
    logic [7:0] r_p2_cnt;
    logic       r_p1_stun;
    logic       r_p2_stun;
    logic       r_p1_conn;
    logic       r_p2_conn;
    logic       r_p1_hit;
    logic       r_p2_hit;

    logic       w_ovl_12;
    logic       w_ovl_21;
    logic       w_p1_lands;
    logic       w_p2_lands;
    logic       w_p1_idle;
    logic       w_p2_idle;
    logic [3:0] w_p1_health_nx;
    logic [3:0] w_p2_health_nx;
    logic [7:0] w_p1_cnt_nx;
    logic [7:0] w_p2_cnt_nx;

    // Inclusive-corner rectangle overlap; touching edges count.
    function automatic logic f_ovl(
        input logic [9:0] ax1, input logic [9:0] ax2,
        input logic [9:0] ay1, input logic [9:0] ay2,
        input logic [9:0] bx1, input logic [9:0] bx2,
        input logic [9:0] by1, input logic [9:0] by2
    );
        return (ax1 <= bx2) && (bx1 <= ax2) &&
               (ay1 <= by2) && (by1 <= ay2);
    endfunction

    always_comb begin
        w_ovl_12 = f_ovl(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                         p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
        w_ovl_21 = f_ovl(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                         p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

        // A stunned defender is untouchable; the attacker's conn flag
        // stays clear so the same swing may land once stun expires.
        w_p1_lands = tick && (r_round == FIGHT) &&
                     (p1_state == ACTIVE_STATE) && !r_p1_conn &&
                     (r_p2_cnt == 8'd0) && w_ovl_12;
        w_p2_lands = tick && (r_round == FIGHT) &&
                     (p2_state == ACTIVE_STATE) && !r_p2_conn &&
                     (r_p1_cnt == 8'd0) && w_ovl_21;

        w_p1_idle = (p1_state <= 4'd2);
        w_p2_idle = (p2_state <= 4'd2);

        w_p1_health_nx = r_p1_health;
        if (w_p2_lands && r_p1_health != 4'd0)
            w_p1_health_nx = r_p1_health - 4'd1;
        w_p2_health_nx = r_p2_health;
        if (w_p1_lands && r_p2_health != 4'd0)
            w_p2_health_nx = r_p2_health - 4'd1;

        // A new hit reloads the counter rather than extending it.
        w_p1_cnt_nx = r_p1_cnt;
        if (w_p2_lands)
            w_p1_cnt_nx = STUN_INIT;
        else if (tick && r_p1_cnt != 8'd0)
            w_p1_cnt_nx = r_p1_cnt - 8'd1;
        w_p2_cnt_nx = r_p2_cnt;
        if (w_p1_lands)
            w_p2_cnt_nx = STUN_INIT;
        else if (tick && r_p2_cnt != 8'd0)
            w_p2_cnt_nx = r_p2_cnt - 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round     <= FIGHT;
            r_p1_health <= HEALTH_INIT;
            r_p2_health <= HEALTH_INIT;
            r_p1_cnt    <= 8'd0;
            r_p2_cnt    <= 8'd0;
            r_p1_stun   <= 1'b0;
            r_p2_stun   <= 1'b0;
            r_p1_conn   <= 1'b0;
            r_p2_conn   <= 1'b0;
            r_p1_hit    <= 1'b0;
            r_p2_hit    <= 1'b0;
        end else if (restart) begin
            r_round     <= FIGHT;
            r_p1_health <= HEALTH_INIT;
            r_p2_health <= HEALTH_INIT;
            r_p1_cnt    <= 8'd0;
            r_p2_cnt    <= 8'd0;
            r_p1_stun   <= 1'b0;
            r_p2_stun   <= 1'b0;
            r_p1_conn   <= 1'b0;
            r_p2_conn   <= 1'b0;
            r_p1_hit    <= 1'b0;
            r_p2_hit    <= 1'b0;
        end else begin
            r_p1_health <= w_p1_health_nx;
            r_p2_health <= w_p2_health_nx;
            r_p1_cnt    <= w_p1_cnt_nx;
            r_p2_cnt    <= w_p2_cnt_nx;
            r_p1_stun   <= (w_p1_cnt_nx != 8'd0);
            r_p2_stun   <= (w_p2_cnt_nx != 8'd0);
            r_p1_hit    <= w_p2_lands;
            r_p2_hit    <= w_p1_lands;

            if (w_p1_lands)
                r_p1_conn <= 1'b1;
            else if (tick && w_p1_idle)
                r_p1_conn <= 1'b0;
            if (w_p2_lands)
                r_p2_conn <= 1'b1;
            else if (tick && w_p2_idle)
                r_p2_conn <= 1'b0;

            // Round outcome uses the health values after this tick's hits.
            if (tick && r_round == FIGHT) begin
                if (w_p1_health_nx == 4'd0 && w_p2_health_nx == 4'd0)
                    r_round <= DRAW;
                else if (w_p2_health_nx == 4'd0)
                    r_round <= P1_WINS;
                else if (w_p1_health_nx == 4'd0)
                    r_round <= P2_WINS;
                else
                    r_round <= FIGHT;
            end
        end
    end

    assign p1_health   = r_p1_health;
    assign p2_health   = r_p2_health;
    assign p1_stun     = r_p1_stun;
    assign p2_stun     = r_p2_stun;
    assign p1_hit      = r_p1_hit;
    assign p2_hit      = r_p2_hit;
    assign round_state = r_round;

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: directed bench for hit_resolver.
// Expected output snapshots are queued as stimulus is driven and popped on check.
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       restart;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [3:0] p1_health, p2_health;
    logic       p1_stun, p2_stun;
    logic       p1_hit, p2_hit;
    logic [1:0] round_state;

    typedef struct {
        string       tag;
        logic [13:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hit_resolver dut (
        .clk(clk), .rst(rst), .tick(tick), .restart(restart),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2),
        .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2),
        .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2),
        .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2),
        .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_stun(p1_stun), .p2_stun(p2_stun),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .round_state(round_state)
    );

    function automatic logic [13:0] mk(
        input logic [3:0] h1, input logic [3:0] h2,
        input logic s1, input logic s2,
        input logic k1, input logic k2,
        input logic [1:0] r
    );
        return {h1, h2, s1, s2, k1, k2, r};
    endfunction

    function automatic logic [13:0] snap();
        return {p1_health, p2_health, p1_stun, p2_stun,
                p1_hit, p2_hit, round_state};
    endfunction

    task automatic expect_state(input string tag, input logic [13:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        q.push_back(x);
    endtask

    task automatic check();
        exp_t        x;
        logic [13:0] obs;
        x   = q.pop_front();
        obs = snap();
        n_tests++;
        assert (obs === x.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
        end
    endtask

    // One frame strobe; returns at the falling edge after it took effect.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; restart = 1'b0;
        p1_state = 4'd0; p2_state = 4'd0;
        p1_hit_x1 = 10'd300; p1_hit_x2 = 10'd340;
        p1_hit_y1 = 10'd100; p1_hit_y2 = 10'd120;
        p2_hurt_x1 = 10'd341; p2_hurt_x2 = 10'd400;
        p2_hurt_y1 = 10'd50;  p2_hurt_y2 = 10'd200;
        p2_hit_x1 = 10'd320; p2_hit_x2 = 10'd360;
        p2_hit_y1 = 10'd60;  p2_hit_y2 = 10'd90;
        p1_hurt_x1 = 10'd800; p1_hurt_x2 = 10'd850;
        p1_hurt_y1 = 10'd400; p1_hurt_y2 = 10'd450;

        repeat (2) @(negedge clk);
        expect_state("reset", mk(3, 3, 0, 0, 0, 0, 0));
        check();
        rst = 1'b0;

        p1_state = 4'd4;
        do_tick();
        expect_state("gap_no_hit", mk(3, 3, 0, 0, 0, 0, 0));
        check();

        p2_hurt_x1 = 10'd340;
        do_tick();
        expect_state("basic_hit", mk(3, 2, 0, 1, 0, 1, 0));
        check();
        @(negedge clk);
        expect_state("hit_pulse_end", mk(3, 2, 0, 1, 0, 0, 0));
        check();

        for (int i = 1; i <= 40; i++) begin
            do_tick();
            expect_state($sformatf("hold_%0d", i),
                         mk(3, 2, 0, (i < 30), 0, 0, 0));
            check();
        end

        p1_state = 4'd0;
        do_tick();
        expect_state("recover_idle", mk(3, 2, 0, 0, 0, 0, 0));
        check();
        p1_state = 4'd3;
        do_tick();
        expect_state("recover_wind", mk(3, 2, 0, 0, 0, 0, 0));
        check();
        p1_state = 4'd4;
        do_tick();
        expect_state("second_hit", mk(3, 1, 0, 1, 0, 1, 0));
        check();

        p1_state = 4'd0;
        wait_ticks(30);
        expect_state("stun_out_2", mk(3, 1, 0, 0, 0, 0, 0));
        check();
        p1_state = 4'd4;
        do_tick();
        expect_state("ko_hit", mk(3, 0, 0, 1, 0, 1, 1));
        check();

        p1_hurt_x1 = 10'd250; p1_hurt_x2 = 10'd330;
        p1_hurt_y1 = 10'd50;  p1_hurt_y2 = 10'd200;
        p2_state = 4'd4;
        p1_state = 4'd0;
        do_tick();
        p1_state = 4'd4;
        do_tick();
        expect_state("ko_frozen", mk(3, 0, 0, 1, 0, 0, 1));
        check();

        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        expect_state("restart", mk(3, 3, 0, 0, 0, 0, 0));
        check();

        do_tick();
        expect_state("trade_1", mk(2, 2, 1, 1, 1, 1, 0));
        check();
        p1_state = 4'd0; p2_state = 4'd0;
        wait_ticks(30);
        expect_state("trade_1_clear", mk(2, 2, 0, 0, 0, 0, 0));
        check();
        p1_state = 4'd4; p2_state = 4'd4;
        do_tick();
        expect_state("trade_2", mk(1, 1, 1, 1, 1, 1, 0));
        check();
        p1_state = 4'd0; p2_state = 4'd0;
        wait_ticks(30);
        p1_state = 4'd4; p2_state = 4'd4;
        do_tick();
        expect_state("draw", mk(0, 0, 1, 1, 1, 1, 3));
        check();
        p1_state = 4'd0; p2_state = 4'd0;
        do_tick();
        expect_state("draw_hold", mk(0, 0, 1, 1, 0, 0, 3));
        check();

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expect_state("async_rst", mk(3, 3, 0, 0, 0, 0, 0));
        check();
        repeat (2) @(negedge clk);
        expect_state("rst_held", mk(3, 3, 0, 0, 0, 0, 0));
        check();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
